turn_light_monitor: RTL and testbench
=====================================

TURN_LIGHT_MONITOR -- requirements
Module: turn_light_monitor

Interface
REQ-001 The module SHALL have these ports (clock and reset first):
  clk        input   1  single system clock; all state changes on rising edge
  reset      input   1  synchronous, active-high reset
  lights     input   6  tail-light pattern {LC,LB,LA,RA,RB,RC}, bit5=LC .. bit0=RC
  mode       output  2  decoded sequence: 00 idle, 01 left, 10 right, 11 hazard
  cycle_done output  1  one-cycle pulse, full sequence completed
  seq_err    output  1  one-cycle pulse, illegal pattern transition
  left_cnt   output  8  completed left sequences, saturating
  right_cnt  output  8  completed right sequences, saturating
  haz_cnt    output  8  completed hazard sequences, saturating
  err_cnt    output  8  illegal transitions, saturating
REQ-002 The module SHALL have one clock, clk; reset SHALL be synchronous and active-high.
REQ-003 The module SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 Legal patterns: OFF=000000, L1=001000, L2=011000, L3=111000, R1=000100, R2=000110, R3=000111, HZ=111111.
REQ-005 States: IDLE, SL1, SL2, SL3, SR1, SR2, SR3, SHZ; every output SHALL be registered.
REQ-006 lights SHALL be sampled on every rising clk edge; state, pulses and counters SHALL update on that same edge (one-cycle latency from input to output).
REQ-007 Start decode: pattern L1 -> SL1, R1 -> SR1, HZ -> SHZ, OFF -> IDLE.
REQ-008 Advance: SL1+L2 -> SL2; SL2+L3 -> SL3; SR1+R2 -> SR2; SR2+R3 -> SR3.
REQ-009 Hold: pattern equal to the current state's own pattern -> stay; no pulse.
REQ-010 Completion: SL3+OFF, SR3+OFF, SHZ+OFF -> IDLE; cycle_done=1 for one cycle; the matching counter increments by 1.
REQ-011 Abort: SL1, SL2, SR1, SR2 + OFF -> IDLE; no pulse; no counter change.
REQ-012 Any other pattern/state combination SHALL be illegal: seq_err=1 for one cycle; err_cnt increments by 1; next state is the start decode (REQ-007) of the same pattern; non-legal patterns go to IDLE.
REQ-013 IDLE receiving L2, L3, R2, R3 or a non-legal pattern SHALL be illegal per REQ-012.
REQ-014 cycle_done and seq_err SHALL never be asserted in the same cycle.
REQ-015 mode SHALL be 01 in SL1-SL3, 10 in SR1-SR3, 11 in SHZ and 00 in IDLE.
REQ-016 All counters SHALL saturate at 255; at 255 a further increment SHALL be ignored and the pulse SHALL still assert.
REQ-017 Back-to-back sequences (OFF followed immediately by L1) SHALL be accepted with no idle gap requirement.

Reset
REQ-018 When reset=1 at a rising edge, the state SHALL go to IDLE; mode SHALL be 00; cycle_done and seq_err SHALL be 0; all counters SHALL be 0; lights SHALL be ignored that cycle.
REQ-019 Reset asserted mid-sequence SHALL discard the sequence; no pulse and no count SHALL result.
REQ-020 On the first edge after reset deasserts, lights SHALL be decoded from IDLE.

Verification
REQ-021 Left sequence: reset, then lights L1,L2,L3,OFF on consecutive edges -> mode 01,01,01,00; cycle_done=1 on the 4th edge only; left_cnt=1.
REQ-022 Hazard with holds: HZ,HZ,HZ,OFF -> mode 11 for 3 cycles; cycle_done on the 4th edge; haz_cnt=1; err_cnt=0.
REQ-023 Illegal jump: L1 then R2 -> seq_err pulse; err_cnt=1; mode 00. L1 then R1 -> seq_err; mode 10 (resynchronised to SR1).
REQ-024 Abort and reset mid-operation: R1,R2,OFF -> no pulse; right_cnt=0. R1,R2 then reset=1 -> all outputs 0; next R3 -> seq_err.
REQ-025 Saturation: 256 complete right sequences -> right_cnt=255; cycle_done still pulses on the 256th.
REQ-026 Back-to-back: L1,L2,L3,OFF,L1,L2,L3,OFF -> two cycle_done pulses; left_cnt=2; seq_err never asserted.

Source files
------------

// File: rtl/turn_light_monitor.sv
// Tail-light sequence monitor: decodes left/right/hazard lamp sequences,
// flags illegal pattern transitions and keeps saturating event counters.
module turn_light_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] lights,
  output logic [1:0] mode,
  output logic       cycle_done,
  output logic       seq_err,
  output logic [7:0] left_cnt,
  output logic [7:0] right_cnt,
  output logic [7:0] haz_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [5:0] P_OFF = 6'b000000;
  localparam logic [5:0] P_L1  = 6'b001000;
  localparam logic [5:0] P_L2  = 6'b011000;
  localparam logic [5:0] P_L3  = 6'b111000;
  localparam logic [5:0] P_R1  = 6'b000100;
  localparam logic [5:0] P_R2  = 6'b000110;
  localparam logic [5:0] P_R3  = 6'b000111;
  localparam logic [5:0] P_HZ  = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  state_t     w_start;
  logic [5:0] w_own;
  logic       w_legal;
  logic       w_done;
  logic       w_inc_l;
  logic       w_inc_r;
  logic       w_inc_h;
  logic [1:0] w_mode_next;

  logic [1:0] r_mode;
  logic       r_done;
  logic       r_err;
  logic [7:0] r_left_cnt;
  logic [7:0] r_right_cnt;
  logic [7:0] r_haz_cnt;
  logic [7:0] r_err_cnt;

  // Where a sequence would begin if this pattern arrived from IDLE.
  always_comb begin
    w_start = S_IDLE;
    case (lights)
      P_L1:    w_start = S_L1;
      P_R1:    w_start = S_R1;
      P_HZ:    w_start = S_HZ;
      default: w_start = S_IDLE;
    endcase
  end

  always_comb begin
    w_own = P_OFF;
    case (r_state)
      S_L1:    w_own = P_L1;
      S_L2:    w_own = P_L2;
      S_L3:    w_own = P_L3;
      S_R1:    w_own = P_R1;
      S_R2:    w_own = P_R2;
      S_R3:    w_own = P_R3;
      S_HZ:    w_own = P_HZ;
      default: w_own = P_OFF;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_legal      = 1'b0;
    w_done       = 1'b0;
    w_inc_l      = 1'b0;
    w_inc_r      = 1'b0;
    w_inc_h      = 1'b0;
    if (lights == w_own) begin
      w_legal = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_legal      = (lights == P_L1) || (lights == P_R1) || (lights == P_HZ);
          w_state_next = w_start;
        end
        S_L1: begin
          if (lights == P_L2) begin w_legal = 1'b1; w_state_next = S_L2; end
          else if (lights == P_OFF) begin w_legal = 1'b1; w_state_next = S_IDLE; end
        end
        S_L2: begin
          if (lights == P_L3) begin w_legal = 1'b1; w_state_next = S_L3; end
          else if (lights == P_OFF) begin w_legal = 1'b1; w_state_next = S_IDLE; end
        end
        S_R1: begin
          if (lights == P_R2) begin w_legal = 1'b1; w_state_next = S_R2; end
          else if (lights == P_OFF) begin w_legal = 1'b1; w_state_next = S_IDLE; end
        end
        S_R2: begin
          if (lights == P_R3) begin w_legal = 1'b1; w_state_next = S_R3; end
          else if (lights == P_OFF) begin w_legal = 1'b1; w_state_next = S_IDLE; end
        end
        S_L3, S_R3, S_HZ: begin
          if (lights == P_OFF) begin
            w_legal      = 1'b1;
            w_done       = 1'b1;
            w_state_next = S_IDLE;
            w_inc_l      = (r_state == S_L3);
            w_inc_r      = (r_state == S_R3);
            w_inc_h      = (r_state == S_HZ);
          end
        end
        default: w_legal = 1'b0;
      endcase
      // Illegal input resynchronises to whatever the pattern would start.
      if (!w_legal) begin
        w_state_next = w_start;
      end
    end
  end

  always_comb begin
    w_mode_next = 2'b00;
    case (w_state_next)
      S_L1, S_L2, S_L3: w_mode_next = 2'b01;
      S_R1, S_R2, S_R3: w_mode_next = 2'b10;
      S_HZ:             w_mode_next = 2'b11;
      default:          w_mode_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_left_cnt  <= 8'd0;
      r_right_cnt <= 8'd0;
      r_haz_cnt   <= 8'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_done  <= w_done;
      r_err   <= !w_legal;
      if (w_inc_l && (r_left_cnt != 8'hFF))  r_left_cnt  <= r_left_cnt + 8'd1;
      if (w_inc_r && (r_right_cnt != 8'hFF)) r_right_cnt <= r_right_cnt + 8'd1;
      if (w_inc_h && (r_haz_cnt != 8'hFF))   r_haz_cnt   <= r_haz_cnt + 8'd1;
      if (!w_legal && (r_err_cnt != 8'hFF))  r_err_cnt   <= r_err_cnt + 8'd1;
    end
  end

  assign mode       = r_mode;
  assign cycle_done = r_done;
  assign seq_err    = r_err;
  assign left_cnt   = r_left_cnt;
  assign right_cnt  = r_right_cnt;
  assign haz_cnt    = r_haz_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_turn_light_monitor.sv
// Bench for turn_light_monitor: a sequence-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_turn_light_monitor;

  localparam logic [5:0] OFF = 6'b000000;
  localparam logic [5:0] L1  = 6'b001000;
  localparam logic [5:0] L2  = 6'b011000;
  localparam logic [5:0] L3  = 6'b111000;
  localparam logic [5:0] R1  = 6'b000100;
  localparam logic [5:0] R2  = 6'b000110;
  localparam logic [5:0] R3  = 6'b000111;
  localparam logic [5:0] HZ  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] lights = OFF;
  logic [1:0] mode;
  logic       cycle_done;
  logic       seq_err;
  logic [7:0] left_cnt;
  logic [7:0] right_cnt;
  logic [7:0] haz_cnt;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  turn_light_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .lights     (lights),
    .mode       (mode),
    .cycle_done (cycle_done),
    .seq_err    (seq_err),
    .left_cnt   (left_cnt),
    .right_cnt  (right_cnt),
    .haz_cnt    (haz_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is a (kind, level) pair; kind 1=left 2=right 3=hazard.
  function automatic void classify(input logic [5:0] p, output int k, output int lv);
    k = -1; lv = 0;
    case (p)
      OFF: begin k = 0; lv = 0; end
      L1:  begin k = 1; lv = 1; end
      L2:  begin k = 1; lv = 2; end
      L3:  begin k = 1; lv = 3; end
      R1:  begin k = 2; lv = 1; end
      R2:  begin k = 2; lv = 2; end
      R3:  begin k = 2; lv = 3; end
      HZ:  begin k = 3; lv = 3; end
      default: begin k = -1; lv = 0; end
    endcase
  endfunction

  bit m_valid = 0;
  int m_kind = 0, m_level = 0;
  int m_done = 0, m_err = 0;
  int m_cnt[4] = '{0, 0, 0, 0};   // index 1..3 completions, 0 errors

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    int k, lv;
    if (reset) begin
      m_valid = 1; m_kind = 0; m_level = 0; m_done = 0; m_err = 0;
      m_cnt = '{0, 0, 0, 0};
    end else begin
      m_done = 0; m_err = 0;
      classify(lights, k, lv);
      if (k < 0) begin
        m_err = 1; m_kind = 0; m_level = 0;
      end else if (k == 0) begin
        if (m_kind != 0 && m_level == 3) begin
          m_done = 1;
          m_cnt[m_kind] = sat_inc(m_cnt[m_kind]);
        end
        m_kind = 0; m_level = 0;
      end else if (k == m_kind && lv == m_level) begin
        // same lamps as now: hold
      end else if (m_kind == 0 && (lv == 1 || k == 3)) begin
        m_kind = k; m_level = lv;
      end else if (k == m_kind && k != 3 && lv == m_level + 1) begin
        m_level = lv;
      end else begin
        m_err = 1;
        if (lv == 1 || k == 3) begin m_kind = k; m_level = lv; end
        else begin m_kind = 0; m_level = 0; end
      end
      if (m_err != 0) m_cnt[0] = sat_inc(m_cnt[0]);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("mode", int'(mode), m_kind);
      check("cycle_done", int'(cycle_done), m_done);
      check("seq_err", int'(seq_err), m_err);
      check("left_cnt", int'(left_cnt), m_cnt[1]);
      check("right_cnt", int'(right_cnt), m_cnt[2]);
      check("haz_cnt", int'(haz_cnt), m_cnt[3]);
      check("err_cnt", int'(err_cnt), m_cnt[0]);
      check("done_err_excl", int'(cycle_done & seq_err), 0);
    end
  end

  task automatic step(input logic [5:0] p, input logic r = 1'b0);
    lights = p;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int errs;

  initial begin
    step(L3, 1'b1);
    step(L3, 1'b1);
    check("rst_mode", int'(mode), 0);
    check("rst_done", int'(cycle_done), 0);
    check("rst_err", int'(seq_err), 0);
    check("rst_cnts", int'(left_cnt) + int'(right_cnt) + int'(haz_cnt) + int'(err_cnt), 0);

    // left sequence
    step(L1); check("left_m1", int'(mode), 1); check("left_d1", int'(cycle_done), 0);
    step(L2); check("left_m2", int'(mode), 1);
    step(L3); check("left_m3", int'(mode), 1); check("left_d3", int'(cycle_done), 0);
    step(OFF);
    check("left_m4", int'(mode), 0);
    check("left_d4", int'(cycle_done), 1);
    check("left_cnt1", int'(left_cnt), 1);

    // hazard with holds
    step(HZ); step(HZ); step(HZ);
    check("haz_m3", int'(mode), 3);
    check("haz_d3", int'(cycle_done), 0);
    step(OFF);
    check("haz_d4", int'(cycle_done), 1);
    check("haz_cnt1", int'(haz_cnt), 1);
    check("haz_errcnt", int'(err_cnt), 0);

    // illegal jumps
    step(L1); step(R2);
    check("jump_err", int'(seq_err), 1);
    check("jump_errcnt", int'(err_cnt), 1);
    check("jump_mode", int'(mode), 0);
    step(L1); step(R1);
    check("resync_err", int'(seq_err), 1);
    check("resync_mode", int'(mode), 2);
    step(OFF);
    check("resync_abort", int'(cycle_done), 0);

    // abort, then reset mid-sequence
    step(R1); step(R2); step(OFF);
    check("abort_done", int'(cycle_done), 0);
    check("abort_rcnt", int'(right_cnt), 0);
    step(R1); step(R2); step(R3, 1'b1);
    check("midrst_mode", int'(mode), 0);
    check("midrst_cnts", int'(left_cnt) + int'(haz_cnt) + int'(err_cnt), 0);
    step(R3);
    check("postrst_err", int'(seq_err), 1);
    check("postrst_errcnt", int'(err_cnt), 1);
    step(OFF);

    // back-to-back left sequences
    step(OFF, 1'b1);
    pulses = 0; errs = 0;
    for (int rep = 0; rep < 2; rep++) begin
      step(L1); errs += seq_err;
      step(L2); errs += seq_err;
      step(L3); errs += seq_err;
      step(OFF); errs += seq_err; pulses += cycle_done;
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_left", int'(left_cnt), 2);
    check("b2b_errs", errs, 0);

    // assorted illegal transitions
    step(L1); step(L2); step(6'b101010);
    check("nonlegal_err", int'(seq_err), 1);
    check("nonlegal_mode", int'(mode), 0);
    step(L1); step(L2); step(L3); step(L1);
    check("l3_l1_err", int'(seq_err), 1);
    check("l3_l1_mode", int'(mode), 1);
    step(HZ);
    check("l1_hz_mode", int'(mode), 3);
    step(L3);
    check("hz_l3_mode", int'(mode), 0);
    step(OFF);

    // right counter saturation
    step(OFF, 1'b1);
    for (int s = 0; s < 256; s++) begin
      step(R1); step(R2); step(R3); step(OFF);
      if (s == 254) check("sat_r255", int'(right_cnt), 255);
    end
    check("sat_done", int'(cycle_done), 1);
    check("sat_rcnt", int'(right_cnt), 255);

    // error counter saturation from IDLE
    step(OFF, 1'b1);
    for (int s = 0; s < 258; s++) step(L2);
    check("esat_cnt", int'(err_cnt), 255);
    check("esat_pulse", int'(seq_err), 1);
    step(OFF);
    step(OFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
